// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and default width.
package alu_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int OP_WIDTH  = 3;

  localparam logic [OP_WIDTH-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_WIDTH-1:0] OP_INC  = 3'b010;
  localparam logic [OP_WIDTH-1:0] OP_DEC  = 3'b011;
  localparam logic [OP_WIDTH-1:0] OP_PASS = 3'b100;
  localparam logic [OP_WIDTH-1:0] OP_NOT  = 3'b101;
  localparam logic [OP_WIDTH-1:0] OP_DIV  = 3'b110;
  localparam logic [OP_WIDTH-1:0] OP_AND  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Command/result handshake bundle between a command source and the sequential ALU.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic                in_valid;
  logic                in_ready;
  logic [OP_WIDTH-1:0] op;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    res;
  logic                zero;
  logic                carry;
  logic                ovf;
  logic                dbz;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, res, zero, carry, ovf, dbz
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, res, zero, carry, ovf, dbz
  );
endinterface

// File: rtl/div_restoring.sv
// Unsigned restoring divider: one quotient bit per clock, WIDTH iterations after start.
module div_restoring
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_busy;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_bit;

  // Remainder stays below the divisor, so a WIDTH+1 difference never wraps past its sign bit.
  always_comb begin
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_div};
    w_bit   = ~w_diff[WIDTH];
  end

  assign quotient = {r_quo[WIDTH-2:0], w_bit};
  assign done     = r_busy && (r_cnt == CNT_W'(1));
  assign busy     = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_cnt  <= CNT_W'(WIDTH);
      r_rem  <= '0;
      r_quo  <= dividend;
      r_div  <= divisor;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      r_quo  <= quotient;
      r_cnt  <= r_cnt - CNT_W'(1);
      if (done) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Sequential 8-op ALU with valid/ready on both sides, registered result/flags and a
// multi-cycle restoring divider.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OP_W  = OP_WIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  alu_seq_if.slave  bus
);
  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;
  logic             r_dbz;

  logic [OP_W-1:0]  w_op;
  logic [WIDTH-1:0] w_rhs;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_dif;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_dbz;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_start;
  logic             w_busy;
  logic             w_done;
  logic             w_div_done;
  logic [WIDTH-1:0] w_quo;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] r);
    return ((x < 0) == (y < 0)) && ((r < 0) != (x < 0));
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] r);
    return ((x < 0) != (y < 0)) && ((r < 0) != (x < 0));
  endfunction

  assign w_op       = bus.op;
  assign w_in_ready = en && (r_state != DIV) && !w_busy && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_start    = w_accept && (w_op == OP_DIV) && (bus.b != '0);
  assign w_div_done = (r_state == DIV) && w_done;

  // inc/dec reuse the add/sub paths with an implicit operand of 1.
  always_comb begin
    w_rhs   = ((w_op == OP_INC) || (w_op == OP_DEC)) ? WIDTH'(1) : bus.b;
    w_sum   = {1'b0, bus.a} + {1'b0, w_rhs};
    w_dif   = bus.a - w_rhs;
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_dbz   = 1'b0;
    case (w_op)
      OP_ADD, OP_INC: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = add_ovf(bus.a, w_rhs, w_sum[WIDTH-1:0]);
      end
      OP_SUB, OP_DEC: begin
        w_res   = w_dif;
        w_carry = bus.a < w_rhs;
        w_ovf   = sub_ovf(bus.a, w_rhs, w_dif);
      end
      OP_PASS: w_res = bus.a;
      OP_NOT:  w_res = ~bus.a;
      OP_DIV: begin
        w_res = '1;
        w_dbz = 1'b1;
      end
      OP_AND:  w_res = bus.a & bus.b;
      default: w_res = '0;
    endcase
  end

  div_restoring #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .dividend (bus.a),
    .divisor  (bus.b),
    .busy     (w_busy),
    .done     (w_done),
    .quotient (w_quo)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = DIV;
      DIV:     if (w_done)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result stage: loads on a non-div accept or on the divider's last iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && !w_start) begin
        r_out_valid <= 1'b1;
        r_res       <= w_res;
        r_zero      <= (w_res == '0);
        r_carry     <= w_carry;
        r_ovf       <= w_ovf;
        r_dbz       <= w_dbz;
      end else if (w_div_done) begin
        r_out_valid <= 1'b1;
        r_res       <= w_quo;
        r_zero      <= (w_quo == '0);
        r_carry     <= 1'b0;
        r_ovf       <= 1'b0;
        r_dbz       <= 1'b0;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.res       = r_res;
  assign bus.zero      = r_zero;
  assign bus.carry     = r_carry;
  assign bus.ovf       = r_ovf;
  assign bus.dbz       = r_dbz;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed commands push expected results, a monitor pops on retire.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W), .OP_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic z, input logic c,
                              input logic o, input logic d);
    exp_t e;
    e.res = r; e.zero = z; e.carry = c; e.ovf = o; e.dbz = d;
    return e;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call between posedge+1 and the following negedge; returns at posedge+1 after the accept.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input exp_t e, input bit push);
    int t;
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.a  = ia;
    bus.b  = ib;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 200) break;
    end
    if (t > 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: op %0d never accepted", o);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (push) q.push_back(e);
      #1;
      bus.in_valid = 1'b0;
      bus.a = $urandom;
      bus.b = $urandom;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: res %0h with empty scoreboard", bus.res);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_res",   64'(bus.res),   64'(e.res));
        chk("sb_zero",  64'(bus.zero),  64'(e.zero));
        chk("sb_carry", 64'(bus.carry), 64'(e.carry));
        chk("sb_ovf",   64'(bus.ovf),   64'(e.ovf));
        chk("sb_dbz",   64'(bus.dbz),   64'(e.dbz));
      end
    end
  end

  initial begin
    int cnt;
    int rdy_hi;
    int vld_hi;
    bit got;

    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_res",       64'(bus.res),       0);
    chk("rst_flags",     64'({bus.zero, bus.carry, bus.ovf, bus.dbz}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    sync();

    // Arithmetic, back-to-back at full throughput
    issue(OP_ADD, 32'hFFFF_FFFF, 32'd1, mk(32'h0, 1, 1, 0, 0), 1);
    issue(OP_SUB, 32'h8000_0000, 32'd1, mk(32'h7FFF_FFFF, 0, 0, 1, 0), 1);
    issue(OP_SUB, 32'd3, 32'd5, mk(32'hFFFF_FFFE, 0, 1, 0, 0), 1);
    issue(OP_INC, 32'h7FFF_FFFF, 32'd0, mk(32'h8000_0000, 0, 0, 1, 0), 1);
    issue(OP_DEC, 32'd0, 32'd0, mk(32'hFFFF_FFFF, 0, 1, 0, 0), 1);
    issue(OP_NOT, 32'd0, 32'd0, mk(32'hFFFF_FFFF, 0, 0, 0, 0), 1);
    @(negedge clk);
    chk("lat1_valid", 64'(bus.out_valid), 1);
    sync();

    // Divide: latency counted in edges including the accept edge
    issue(OP_DIV, 32'd1000, 32'd7, mk(32'd142, 0, 0, 0, 0), 1);
    cnt = 1;
    rdy_hi = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid || cnt > 100) break;
      if (bus.in_ready) rdy_hi++;
      @(posedge clk);
      cnt++;
    end
    chk("div_latency", 64'(cnt), 64'(W + 1));
    chk("div_busy_ready", 64'(rdy_hi), 0);
    sync();
    issue(OP_DIV, 32'd5, 32'd0, mk(32'hFFFF_FFFF, 0, 0, 0, 1), 1);
    @(negedge clk);
    chk("dbz_latency", 64'(bus.out_valid), 1);
    sync();

    // Backpressure, then retire and accept on the same edge
    bus.out_ready = 1'b0;
    issue(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, mk(32'h0000_00F0, 0, 0, 0, 0), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.out_valid), 1);
      chk("bp_res",   64'(bus.res), 64'h00F0);
      chk("bp_ready", 64'(bus.in_ready), 0);
    end
    sync();
    bus.out_ready = 1'b1;
    issue(OP_INC, 32'd9, 32'd0, mk(32'd10, 0, 0, 0, 0), 1);
    @(negedge clk);
    chk("b2b_valid", 64'(bus.out_valid), 1);
    sync();

    // en gating
    en = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = OP_PASS;
    bus.a  = 32'd42;
    bus.b  = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en_ready",   64'(bus.in_ready), 0);
      chk("en_noaccept", 64'(bus.out_valid), 0);
    end
    sync();
    en = 1'b1;
    issue(OP_PASS, 32'd42, 32'd0, mk(32'd42, 0, 0, 0, 0), 1);
    @(negedge clk);
    chk("en_lat1", 64'(bus.out_valid), 1);
    sync();

    // en dropped while dividing
    issue(OP_DIV, 32'd100, 32'd7, mk(32'd14, 0, 0, 0, 0), 1);
    en = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("div_en_low_done", 64'(got), 1);
    sync();
    en = 1'b1;

    // Reset in the middle of a divide discards it
    issue(OP_DIV, 32'd100, 32'd7, mk(32'd14, 0, 0, 0, 0), 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 0);
    chk("mid_rst_res",   64'(bus.res), 0);
    chk("mid_rst_flags", 64'({bus.zero, bus.carry, bus.ovf, bus.dbz}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    vld_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) vld_hi++;
    end
    chk("mid_rst_no_output", 64'(vld_hi), 0);
    chk("mid_rst_ready", 64'(bus.in_ready), 1);

    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
